rtr_out_port_arbiter: RTL and testbench
=======================================

Name: rtr_out_port_arbiter

Overview:
- Sequential arbiter in front of one router output port. Four input channels compete for that port.
- Per-cycle priority decisions from the combinational route-select logic become packet-locked grants.
- Selection rule: highest 3-bit priority wins; ties are broken round-robin.
- A grant is held until the winning packet's tail transfers. This gives the downstream datapath a stable one-hot select.

Parameters:
- N, 4, number of requesting channels (gnt_id width is $clog2(N), minimum 1).
- PW, 3, priority field width per channel. Larger value means higher priority.
- WAIT_W, 4, width of the per-channel starvation counter (used only with the optional feature).
- STARVE_LIMIT, 12, counter value at which a waiting channel is forced to win (must be < 2**WAIT_W).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-channel request (head flit present).
- prio  in  N*PW  per-channel priority; channel i occupies bits [i*PW +: PW].
- last  in  N  per-channel tail flag, qualified by the transfer condition.
- out_ready  in  1  downstream can accept a flit this cycle.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  clog2(N)  registered index of granted channel; 0 when idle.
- xfer  out  1  combinational; gnt_valid & req[gnt_id] & out_ready.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, gnt_valid=0, gnt_id=0.
  - rr_ptr=0, state=IDLE, wait counters=0.
- Two-state FSM, IDLE and LOCKED.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner:
    - Candidates are the requesting channels holding the maximum prio value.
    - Among candidates, choose the first one found scanning upward from rr_ptr, wrapping N-1 to 0.
  - Next cycle: gnt=onehot(winner), gnt_id=winner, state=LOCKED.
  - Request-to-grant latency is exactly 1 cycle.
- LOCKED:
  - gnt, gnt_id and priority are frozen. Changes to prio or req on other channels are ignored.
  - A release happens in any of these cycles:
    - xfer & last[gnt_id] (normal tail).
    - req[gnt_id]==0 (abandon; takes precedence, no xfer).
  - On release, next cycle: gnt=0, state=IDLE, rr_ptr=(gnt_id+1) mod N.
  - Otherwise stay in LOCKED.
- Re-arbitration spacing:
  - No re-arbitration occurs in the release cycle. A minimum of one idle cycle separates consecutive grants.
  - Consecutive grants are therefore at least 2 cycles apart, including back-to-back packets from the same channel.
- Single-flit packet: if req and last are high and out_ready is high in the first LOCKED cycle, the grant lasts exactly 1 cycle.
- out_ready low holds LOCKED indefinitely. There is no timeout.
- Priority ties with all PW bits zero still arbitrate normally. Priority 0 is valid, not "no request".
- rr_ptr advances only on release, never on idle cycles.
- Reset asserted mid-packet clears everything at once. After rst_n deasserts, the first grant follows the normal IDLE rules with rr_ptr=0.

Optional Feature:
- Macro: RTR_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - Each channel has a WAIT_W-bit saturating counter.
  - In every IDLE cycle that makes a decision, the counter increments for each channel where req[i]=1 and i != winner. The winner's counter clears.
  - A counter also clears in any cycle with req[i]=0.
  - A counter reaching STARVE_LIMIT marks that channel starving. If any channel is starving, candidates = starving requesting channels, regardless of prio; the round-robin tie-break still applies.
  - Counters hold in LOCKED. Reset clears all counters.
- Without the macro: no counters exist and selection is strict priority plus round-robin, as above.

Decomposition:
- Package rtr_arb_pkg:
  - Typedef arb_state_e {IDLE, LOCKED}.
  - Localparam defaults N_DEF=4, PW_DEF=3.
  - Function onehot_to_idx.
- One sub-module, rtr_rr_pick:
  - Purely combinational.
  - Inputs: candidate mask and rr_ptr. Outputs: winner index and found flag.
  - Rotate-mask-based first-one search.
- The top level holds the FSM, max-priority candidate masking, the lock registers and the starvation counters.

Test Plan:
- Reset then req=4'b0110, prio ch1=5, ch2=5, rr_ptr=0 -> one cycle later gnt=4'b0010, gnt_id=1. After last on ch1 with out_ready=1: gnt=0 for one cycle, then gnt=4'b0100 (rr_ptr=2).
- req=4'b1111, prio ch0=2, ch1=7, ch2=3, ch3=7, rr_ptr=2 -> gnt=4'b1000. During LOCKED, raising prio ch0 to 7 leaves gnt unchanged.
- Granted ch0 with 3-flit packet, out_ready pattern 1,0,1,1, last on the 3rd transfer -> exactly 3 xfer pulses, gnt held 4 cycles, gnt=0 on the 5th.
- Granted ch2 with req[2] dropped mid-packet (no last) -> next cycle gnt=0, state IDLE, rr_ptr=3.
- rst_n pulsed low mid-packet while gnt=4'b0100 -> gnt=0 and gnt_valid=0 immediately (asynchronous). First grant afterwards follows rr_ptr=0.
- With RTR_ARB_STARVE_GUARD_EN and STARVE_LIMIT=12: ch0 prio 0 requesting continuously, ch3 prio 7 sending back-to-back single-flit packets -> ch0 granted on the 13th arbitration decision. Without the macro, ch0 is never granted.

Source files
------------

// File: rtl/rtr_arb_pkg.sv
// Shared types and helpers for the router output-port arbiter.
package rtr_arb_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned PW_DEF = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector (0 for an all-zero vector).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rtr_rr_pick.sv
// Round-robin first-one search: rotate the candidate mask so rr_ptr_i sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rtr_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  cand_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0] rot;
  logic         hit;
  int unsigned  off;
  int unsigned  sum;

  always_comb begin
    rot = N'({cand_i, cand_i} >> rr_ptr_i);
    off = 0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (rot[k] && !hit) begin
        off = unsigned'(k);
        hit = 1'b1;
      end
    end
    sum = 32'(rr_ptr_i) + off;
    if (sum >= N) sum = sum - N;
    idx_o   = IW'(sum);
    found_o = hit;
  end

endmodule

// File: rtl/rtr_out_port_arbiter.sv
// Packet-locked priority/round-robin arbiter for one router output port.
// Optional starvation guard enabled by defining RTR_ARB_STARVE_GUARD_EN.
module rtr_out_port_arbiter
  import rtr_arb_pkg::*;
#(
  parameter  int unsigned N            = N_DEF,
  parameter  int unsigned PW           = PW_DEF,
  parameter  int unsigned WAIT_W       = 4,
  parameter  int unsigned STARVE_LIMIT = 12,
  localparam int unsigned IW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic [N-1:0]    last,
  input  logic            out_ready,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_id,
  output logic            xfer
);

  if (STARVE_LIMIT >= (32'd1 << WAIT_W)) begin : g_cfg_check
    $error("STARVE_LIMIT must be below 2**WAIT_W");
  end

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic [PW-1:0] max_prio;
  logic [N-1:0]  prio_cand;
  logic [N-1:0]  cand;
  logic [IW-1:0] win;
  logic          found;
  logic          decide;
  logic          rel;

  // Requesting channels that hold the highest priority value.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (prio[i*PW +: PW] > max_prio)) max_prio = prio[i*PW +: PW];
    end
    for (int i = 0; i < N; i++) begin
      prio_cand[i] = req[i] && (prio[i*PW +: PW] == max_prio);
    end
  end

`ifdef RTR_ARB_STARVE_GUARD_EN
  logic [N-1:0][WAIT_W-1:0] wait_q, wait_d;
  logic [N-1:0]             starve;

  // Starving requesters override priority; counters move only on decisions.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      starve[i] = req[i] && (wait_q[i] >= WAIT_W'(STARVE_LIMIT));
      wait_d[i] = wait_q[i];
      if (!req[i]) begin
        wait_d[i] = '0;
      end else if (decide) begin
        if (win == IW'(i)) wait_d[i] = '0;
        else if (wait_q[i] != {WAIT_W{1'b1}}) wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  assign cand = (|starve) ? starve : prio_cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign cand = prio_cand;
`endif

  rtr_rr_pick #(.N(N), .IW(IW)) u_pick (
    .cand_i   (cand),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (win),
    .found_o  (found)
  );

  assign xfer = gnt_valid_q & req[gnt_id_q] & out_ready;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    decide      = 1'b0;
    rel         = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          decide      = 1'b1;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = IW'(onehot_to_idx(32'(gnt_d)));
          gnt_valid_d = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        // Abandon (request dropped) releases just like a transferred tail.
        rel = !req[gnt_id_q] || (xfer && last[gnt_id_q]);
        if (rel) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          rr_ptr_d    = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rtr_out_port_arbiter.sv
// Self-checking bench for rtr_out_port_arbiter: per-cycle reference model plus
// directed scenarios with literal expectations (RTR_ARB_STARVE_GUARD_EN aware).
module tb_rtr_out_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] prio;
  logic [3:0]  last;
  logic        out_ready;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        xfer;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_rr    = 0;
`ifdef RTR_ARB_STARVE_GUARD_EN
  int m_cnt[4] = '{0, 0, 0, 0};
`endif

  rtr_out_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .prio      (prio),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .xfer      (xfer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pr(input int i);
    logic [11:0] t;
    t = prio >> (3 * i);
    return int'(t[2:0]);
  endfunction

  function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  // One clock of the arbitration rules, evaluated on the inputs seen at the edge.
  task automatic model_step();
    int w, best, c;
    logic [3:0] cs;
`ifdef RTR_ARB_STARVE_GUARD_EN
    bit anys;
`endif
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_rr = 0;
`ifdef RTR_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
      return;
    end
    w = -1;
    if (!m_busy) begin
      if (req != 4'b0) begin
        best = -1;
        for (int i = 0; i < 4; i++) if (req[i] && pr(i) > best) best = pr(i);
        for (int i = 0; i < 4; i++) cs[i] = req[i] && (pr(i) == best);
`ifdef RTR_ARB_STARVE_GUARD_EN
        anys = 1'b0;
        for (int i = 0; i < 4; i++) if (req[i] && m_cnt[i] >= 12) anys = 1'b1;
        if (anys) for (int i = 0; i < 4; i++) cs[i] = req[i] && (m_cnt[i] >= 12);
`endif
        for (int k = 0; k < 4; k++) begin
          c = (m_rr + k) % 4;
          if (w < 0 && cs[c]) w = c;
        end
        m_busy = 1'b1;
        m_owner = w;
      end
    end else if (!req[m_owner] || (out_ready && last[m_owner])) begin
      m_busy = 1'b0;
      m_rr = (m_owner + 1) % 4;
    end
`ifdef RTR_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      if (!req[i]) m_cnt[i] = 0;
      else if (w >= 0) m_cnt[i] = (i == w) ? 0 : ((m_cnt[i] < 15) ? m_cnt[i] + 1 : 15);
    end
`endif
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every falling edge: all outputs against the model.
  initial forever begin
    logic [3:0] eg;
    @(negedge clk);
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_gnt_valid", 32'(gnt_valid), 32'(m_busy));
    chk("model_gnt_id", 32'(gnt_id), m_busy ? 32'(m_owner) : 32'd0);
    chk("model_xfer", 32'(xfer), 32'(m_busy && req[m_owner] && out_ready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] r, input logic [11:0] p, input logic [3:0] l, input logic rdy);
    req = r; prio = p; last = l; out_ready = rdy;
  endtask

  initial begin
    logic [3:0] pat;
    int nx, decisions, ch0_at, exp_at;
    logic prev_v;

    rst_n = 1'b0;
    drv(4'b0000, 12'h0, 4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("reset_gnt_id", 32'(gnt_id), 32'h0);
    rst_n = 1'b1;

    // Tie ch1/ch2 at prio 5, rr_ptr=0 -> ch1, then ch2 after release
    drv(4'b0110, pk(0, 5, 5, 0), 4'b0000, 1'b1);
    tick();
    chk("tie_gnt_ch1", 32'(gnt), 32'h2);
    chk("tie_id_ch1", 32'(gnt_id), 32'h1);
    last = 4'b0010;
    tick();
    chk("tie_release_gap", 32'(gnt), 32'h0);
    last = 4'b0000;
    tick();
    chk("tie_gnt_ch2", 32'(gnt), 32'h4);
    chk("tie_id_ch2", 32'(gnt_id), 32'h2);
    last = 4'b0100;
    tick();

    // Highest priority wins; priority frozen while locked
    drv(4'b1111, pk(2, 7, 3, 7), 4'b0000, 1'b1);
    tick();
    chk("prio_gnt_ch3", 32'(gnt), 32'h8);
    prio = pk(7, 7, 3, 7);
    tick();
    chk("prio_frozen_1", 32'(gnt), 32'h8);
    tick();
    chk("prio_frozen_2", 32'(gnt), 32'h8);
    last = 4'b1000;
    tick();
    chk("prio_release", 32'(gnt), 32'h0);

    // 3-flit packet on ch0 with out_ready pattern 1,0,1,1
    drv(4'b0001, pk(1, 0, 0, 0), 4'b0000, 1'b1);
    tick();
    pat = 4'b1101;
    nx = 0;
    for (int c = 0; c < 4; c++) begin
      out_ready = pat[c];
      last = (c == 3) ? 4'b0001 : 4'b0000;
      #1;
      if (xfer) nx++;
      chk("pkt3_gnt_held", 32'(gnt), 32'h1);
      tick();
    end
    chk("pkt3_xfer_count", 32'(nx), 32'd3);
    chk("pkt3_gnt_off", 32'(gnt), 32'h0);
    drv(4'b0000, 12'h0, 4'b0000, 1'b1);
    tick();

    // Abandon on ch2 -> rr_ptr=3, seen through an all-zero-priority tie
    drv(4'b0100, pk(0, 0, 4, 0), 4'b0000, 1'b1);
    tick();
    chk("abandon_gnt_ch2", 32'(gnt), 32'h4);
    tick();
    req = 4'b0000;
    tick();
    chk("abandon_release", 32'(gnt), 32'h0);
    drv(4'b1111, pk(0, 0, 0, 0), 4'b0000, 1'b1);
    tick();
    chk("abandon_rr3_gnt", 32'(gnt), 32'h8);
    last = 4'b1000;
    tick();

    // Single-flit packet on ch1 lasts one cycle
    drv(4'b0010, pk(0, 2, 0, 0), 4'b0010, 1'b1);
    tick();
    chk("single_gnt", 32'(gnt), 32'h2);
    tick();
    chk("single_off", 32'(gnt), 32'h0);

    // Asynchronous reset mid-packet on ch2
    drv(4'b0100, pk(0, 0, 2, 0), 4'b0000, 1'b1);
    tick();
    chk("rst_pre_gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_valid", 32'(gnt_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    drv(4'b1111, pk(3, 3, 3, 3), 4'b0000, 1'b1);
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    drv(4'b0000, 12'h0, 4'b0000, 1'b1);
    tick();

    // Starvation: ch0 prio 0 vs ch3 prio 7 single-flit back-to-back
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drv(4'b1001, pk(0, 0, 0, 7), 4'b1000, 1'b1);
    decisions = 0;
    ch0_at = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 50 && ch0_at == 0; c++) begin
      tick();
      if (gnt_valid && !prev_v) begin
        decisions++;
        if (gnt[0]) ch0_at = decisions;
      end
      prev_v = gnt_valid;
    end
`ifdef RTR_ARB_STARVE_GUARD_EN
    exp_at = 13;
`else
    exp_at = 0;
`endif
    chk("starve_ch0_decision", 32'(ch0_at), 32'(exp_at));
    drv(4'b0000, 12'h0, 4'b0000, 1'b1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
